// File: rtl/de4_qsys_onchip_mem_checker.sv
// de4_qsys_onchip_mem_checker: write-then-read-back self test of an on-chip RAM, counting mismatching words.
// Define ONCHIP_MEM_CHECKER_LFSR_EN to use a Galois LFSR data pattern instead of the address-derived one.
module de4_qsys_onchip_mem_checker #(
    parameter int          DEPTH = 32000,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [14:0] first_err_addr,
    output logic [14:0] address,
    output logic [3:0]  byteenable,
    output logic        chipselect,
    output logic        write,
    output logic [31:0] writedata,
    output logic        clken,
    input  logic [31:0] readdata
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_t;
    localparam logic [14:0] LAST = 15'(DEPTH - 1);
    state_t      state, state_nxt;
    logic [14:0] addr, addr_nxt;
    logic [31:0] pat;
    logic [31:0] exp_q;
    logic [14:0] cmp_addr;
    logic        cmp_valid;
    logic        last, accept, active;
    assign last   = addr == LAST;
    assign accept = start && (state == IDLE || state == FIN);
    assign active = state == WRITE || state == READ;
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        case (state)
            IDLE, FIN: begin
                state_nxt = accept ? WRITE : state;
                addr_nxt  = 15'd0;
            end
            WRITE: begin
                state_nxt = last ? READ : WRITE;
                addr_nxt  = last ? 15'd0 : addr + 15'd1;
            end
            READ: begin
                state_nxt = last ? DRAIN : READ;
                addr_nxt  = last ? 15'd0 : addr + 15'd1;
            end
            DRAIN:   state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            addr  <= 15'd0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end
`ifdef ONCHIP_MEM_CHECKER_LFSR_EN
    localparam logic [31:0] POLY     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    logic [31:0] lfsr;
    // Rewinding to the seed at the WRITE->READ turn replays the same sequence for checking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lfsr <= 32'd0;
        else if (accept || (state == WRITE && last))
            lfsr <= SEED_EFF;
        else if (active)
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'd0);
    end
    assign pat = lfsr;
`else
    assign pat = SEED ^ {1'b0, ~addr, 1'b0, addr};
`endif
    assign busy       = active || state == DRAIN;
    assign chipselect = active;
    assign clken      = active;
    assign write      = state == WRITE;
    assign address    = active ? addr : 15'd0;
    assign byteenable = active ? 4'hF : 4'h0;
    assign writedata  = write ? pat : 32'd0;
    assign pass       = done && err_count == 16'd0;
    // readdata lags the issued address by one cycle, so the expectation is staged alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q          <= 32'd0;
            cmp_addr       <= 15'd0;
            cmp_valid      <= 1'b0;
            err_count      <= 16'd0;
            first_err_addr <= 15'd0;
            done           <= 1'b0;
        end else begin
            cmp_valid <= state == READ;
            exp_q     <= state == READ ? pat : 32'd0;
            cmp_addr  <= state == READ ? addr : 15'd0;
            if (accept) begin
                done           <= 1'b0;
                err_count      <= 16'd0;
                first_err_addr <= 15'd0;
            end else if (cmp_valid && readdata != exp_q) begin
                err_count      <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
                first_err_addr <= (err_count == 16'd0) ? cmp_addr : first_err_addr;
            end
            if (state == DRAIN)
                done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_de4_qsys_onchip_mem_checker.sv
// tb_de4_qsys_onchip_mem_checker: directed runs against a 16-word 1-cycle RAM model with injectable read faults.
module tb_de4_qsys_onchip_mem_checker;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done, pass, chipselect, write, clken;
    logic [15:0] err_count;
    logic [14:0] first_err_addr, address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata = 32'd0;
    logic [31:0] mem  [0:15];
    logic [31:0] flip [0:15];
    logic [31:0] wd_log [0:15];
    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int cs_cnt = 0;
    int cyc, wr0, rd0, cs0;

`ifdef ONCHIP_MEM_CHECKER_LFSR_EN
    localparam logic [31:0] TB_SEED = 32'h0;
`else
    localparam logic [31:0] TB_SEED = 32'h1;
`endif

    de4_qsys_onchip_mem_checker #(.DEPTH(16), .SEED(TB_SEED)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .write(write), .writedata(writedata),
        .clken(clken), .readdata(readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (chipselect) cs_cnt <= cs_cnt + 1;
        if (chipselect && clken) begin
            if (write) begin
                mem[address[3:0]]    <= writedata;
                wd_log[address[3:0]] <= writedata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                readdata <= mem[address[3:0]] ^ flip[address[3:0]];
                rd_cnt   <= rd_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_to_done(output int n);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_cs"},   32'(chipselect), 32'd0);
        chk({tag, "_wr"},   32'(write), 32'd0);
        chk({tag, "_clken"}, 32'(clken), 32'd0);
        chk({tag, "_addr"}, 32'(address), 32'd0);
        chk({tag, "_be"},   32'(byteenable), 32'd0);
        chk({tag, "_wd"},   writedata, 32'd0);
        chk({tag, "_err"},  32'(err_count), 32'd0);
        chk({tag, "_ferr"}, 32'(first_err_addr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) flip[i] = 32'd0;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset_done", 32'(done), 32'd0);
        reset_n = 1'b1;

        wr0 = wr_cnt; rd0 = rd_cnt;
        run_to_done(cyc);
        chk("clean_cycles", 32'(cyc), 32'd33);
        chk("clean_done", 32'(done), 32'd1);
        chk("clean_pass", 32'(pass), 32'd1);
        chk("clean_err", 32'(err_count), 32'd0);
        chk("clean_writes", 32'(wr_cnt - wr0), 32'd16);
        chk("clean_reads", 32'(rd_cnt - rd0), 32'd16);
        chk("fin_cs", 32'(chipselect), 32'd0);
        chk("fin_busy", 32'(busy), 32'd0);
`ifdef ONCHIP_MEM_CHECKER_LFSR_EN
        chk("lfsr_wd0", wd_log[0], 32'h0000_0001);
        chk("lfsr_wd1", wd_log[1], 32'h8020_0003);
`else
        chk("pat_wd0", wd_log[0], 32'h7FFF_0001);
        chk("pat_wd3", wd_log[3], 32'h7FFC_0002);
`endif

        flip[5] = 32'h1;
        run_to_done(cyc);
        chk("one_err_count", 32'(err_count), 32'd1);
        chk("one_err_first", 32'(first_err_addr), 32'd5);
        chk("one_err_pass", 32'(pass), 32'd0);
        chk("one_err_done", 32'(done), 32'd1);

        flip[5] = 32'd0; flip[2] = 32'h8000_0000; flip[9] = 32'h0000_0100; flip[14] = 32'hFFFF_FFFF;
        run_to_done(cyc);
        chk("three_err_count", 32'(err_count), 32'd3);
        chk("three_err_first", 32'(first_err_addr), 32'd2);
        chk("three_err_pass", 32'(pass), 32'd0);
        flip[2] = 32'd0; flip[9] = 32'd0; flip[14] = 32'd0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(write && address == 15'd7) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_write7", 32'(address), 32'd7);
        #2 reset_n = 1'b0;
        #1 check_idle("async_rst");
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        cs0 = cs_cnt;
        repeat (6) @(negedge clk);
        chk("no_cs_after_rst", 32'(cs_cnt - cs0), 32'd0);
        run_to_done(cyc);
        chk("post_rst_pass", 32'(pass), 32'd1);
        chk("post_rst_cycles", 32'(cyc), 32'd33);

        wr0 = wr_cnt; rd0 = rd_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_one_run_writes", 32'(wr_cnt - wr0), 32'd16);
        chk("held_one_run_reads", 32'(rd_cnt - rd0), 32'd16);
        chk("held_fin_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("held_restart_busy", 32'(busy), 32'd1);
        chk("held_restart_done", 32'(done), 32'd0);
        chk("held_restart_write", 32'(write), 32'd1);
        chk("held_restart_addr", 32'(address), 32'd0);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_second_pass", 32'(pass), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
